// File: rtl/bus_xfer_arbiter.sv
// Two-requester arbiter/sequencer for the shared 16-bit datapath bus.
// Define BUS_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module bus_xfer_arbiter #(
    parameter int SEL_W    = 4,
    parameter int DST_W    = 10,
    parameter int MEM_WAIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [SEL_W-1:0] src0,
    input  logic [SEL_W-1:0] src1,
    input  logic [DST_W-1:0] dst0,
    input  logic [DST_W-1:0] dst1,
    output logic [SEL_W-1:0] bus_sel,
    output logic [DST_W-1:0] dst_we,
    output logic [1:0]       gnt,
    output logic [1:0]       ack,
    output logic             err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam bit         HAS_WAIT = (MEM_WAIT > 0);
    localparam logic [3:0] CNT_INIT = HAS_WAIT ? 4'(MEM_WAIT - 1) : 4'd0;

    localparam logic [SEL_W-1:0] SRC_FIRST = SEL_W'(1);
    localparam logic [SEL_W-1:0] SRC_LAST  = SEL_W'(10);
    localparam logic [SEL_W-1:0] SRC_PRAM  = SEL_W'(9);
    localparam logic [SEL_W-1:0] SRC_DRAM  = SEL_W'(10);

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       cnt_q;
    logic [3:0]       cnt_d;
    logic [SEL_W-1:0] src_q;
    logic [DST_W-1:0] dst_q;
    logic             win_q;
    logic             bad_q;

    logic             win_d;
    logic             grant;
    logic [SEL_W-1:0] src_pick;
    logic [DST_W-1:0] dst_pick;
    logic             pick_bad;
    logic             pick_mem;

    assign grant = (state_q == IDLE) && (req != 2'b00);

`ifdef BUS_ARB_RR_EN
    // ptr_q names the requester that wins the next contended grant.
    logic ptr_q;

    assign win_d = (req == 2'b11) ? ptr_q : req[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (grant) begin
            ptr_q <= ~win_d;
        end
    end
`else
    assign win_d = req[1] & ~req[0];
`endif

    assign src_pick = win_d ? src1 : src0;
    assign dst_pick = win_d ? dst1 : dst0;
    assign pick_bad = (src_pick < SRC_FIRST) || (src_pick > SRC_LAST);
    assign pick_mem = (src_pick == SRC_PRAM) || (src_pick == SRC_DRAM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Transfer parameters are frozen at grant; later req/src/dst changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q <= '0;
            dst_q <= '0;
            win_q <= 1'b0;
            bad_q <= 1'b0;
        end else if (grant) begin
            src_q <= src_pick;
            dst_q <= dst_pick;
            win_q <= win_d;
            bad_q <= pick_bad;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    if (pick_mem && HAS_WAIT) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = WRITE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // All outputs decode from registered state only.
    always_comb begin
        busy    = 1'b0;
        gnt     = 2'b00;
        bus_sel = '0;
        dst_we  = '0;
        ack     = 2'b00;
        err     = 1'b0;
        if (state_q != IDLE) begin
            busy    = 1'b1;
            gnt     = win_q ? 2'b10 : 2'b01;
            bus_sel = src_q;
        end
        if (state_q == WRITE) begin
            ack = win_q ? 2'b10 : 2'b01;
            err = bad_q;
            if (!bad_q) begin
                dst_we = dst_q;
            end
        end
    end

endmodule
